// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, arbiter FSM encoding and the latched data-request record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_IACC = 2'd1;
  localparam logic [1:0] ARB_DACC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ARB_IDLE,
    IACC = ARB_IACC,
    DACC = ARB_DACC
  } arb_state_t;

  typedef struct packed {
    word_t addr;
    word_t data;
    logic  wr;
  } dmem_req_t;

endpackage

// File: rtl/grant_streak_counter.sv
// Saturating count of back-to-back data grants taken while a fetch waits.
// force_fetch_o rises once the count reaches MAX_DSTREAK.
module grant_streak_counter #(
  parameter int MAX_DSTREAK = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear_i,
  input  logic inc_i,
  output logic force_fetch_o
);

  localparam int CW = $clog2(MAX_DSTREAK + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DSTREAK);

  logic [CW-1:0] streak_q;
  logic [CW-1:0] streak_d;

  always_comb begin
    streak_d = streak_q;
    if (clear_i) begin
      streak_d = '0;
    end else if (inc_i && (streak_q != MAX_CNT)) begin
      streak_d = streak_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign force_fetch_o = (streak_q == MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-ported unified RAM; data wins ties unless the
// streak counter forces a pending fetch through.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready
);

  arb_state_t state_q, state_d;
  word_t      iaddr_q, iaddr_d;
  dmem_req_t  dreq_q, dreq_d;

  logic d_req;
  logic i_done;
  logic d_done;
  logic force_fetch;

  assign d_req  = dREN | dWEN;
  assign i_done = (state_q == IACC) & ram_ready;
  assign d_done = (state_q == DACC) & ram_ready;

  // dREN together with dWEN is latched as a write.
  always_comb begin
    state_d = state_q;
    iaddr_d = iaddr_q;
    dreq_d  = dreq_q;
    case (state_q)
      IDLE: begin
        if (d_req && (!iREN || !force_fetch)) begin
          dreq_d  = '{addr: daddr, data: dstore, wr: dWEN};
          state_d = DACC;
        end else if (iREN) begin
          iaddr_d = iaddr;
          state_d = IACC;
        end
      end
      IACC: if (ram_ready) state_d = IDLE;
      DACC: if (ram_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      iaddr_q <= '0;
      dreq_q  <= '0;
    end else begin
      state_q <= state_d;
      iaddr_q <= iaddr_d;
      dreq_q  <= dreq_d;
    end
  end

  grant_streak_counter #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) u_streak (
    .CLK          (CLK),
    .nRST         (nRST),
    .clear_i      (i_done | (d_done & ~iREN)),
    .inc_i        (d_done & iREN),
    .force_fetch_o(force_fetch)
  );

  // Strobes decode straight from state so an async reset drops them immediately.
  assign ramREN   = (state_q == IACC) | ((state_q == DACC) & ~dreq_q.wr);
  assign ramWEN   = (state_q == DACC) & dreq_q.wr;
  assign ramstore = ramWEN ? dreq_q.data : '0;

  always_comb begin
    ramaddr = '0;
    if (state_q == IACC) begin
      ramaddr = iaddr_q;
    end else if (state_q == DACC) begin
      ramaddr = dreq_q.addr;
    end
  end

  // A master that withdrew its request mid-access gets no completion pulse.
  assign iwait = ~(i_done & iREN);
  assign dwait = ~(d_done & d_req);
  assign iload = (i_done & iREN) ? ramload : '0;
  assign dload = (d_done & d_req & ~dreq_q.wr) ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by randomized fetch/load/store traffic against a RAM model
// and a transaction-level reference memory with a data-streak bound.
module tb_mem_arbiter;

  localparam int MAX = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic [31:0] iload, dload;
  logic        iwait, dwait;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload = '0;
  logic        ram_ready = 1'b0;

  int n_assert = 0;
  int n_fail = 0;

  int lat = 1;
  bit rand_lat = 0;
  bit spurious = 0;

  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  mem_arbiter #(.MAX_DSTREAK(MAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // RAM model: ready after cur_lat strobe cycles of one access.
  initial begin
    int age;
    int cur_lat;
    age = 0;
    cur_lat = 1;
    forever begin
      @(posedge CLK);
      #1;
      ram_ready = 1'b0;
      ramload   = '0;
      if (!nRST) begin
        age = 0;
      end else if (ramREN || ramWEN) begin
        if (age == 0) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat;
        age++;
        if (age >= cur_lat) begin
          age = 0;
          ram_ready = 1'b1;
          if (ramWEN) ram_mem[ramaddr] = ramstore;
          else        ramload = ram_rd(ramaddr);
        end
      end else begin
        age = 0;
        if (spurious && ($urandom_range(0, 3) == 0)) begin
          ram_ready = 1'b1;
          ramload   = $urandom;
        end
      end
    end
  end

  initial begin
    int ip, dp, i_at, d_at, nc;
    logic [9:0] seq;
    bit i_pend, d_pend, d_wr;
    int mstreak, i_done_n, d_done_n;

    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    #2;
    chk("rst_ren", ramREN, 0);
    chk("rst_wen", ramWEN, 0);
    chk("rst_addr", ramaddr, 0);
    chk("rst_store", ramstore, 0);
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    cyc(); cyc();
    nRST = 1'b1;
    cyc();

    // Fetch only, ready two cycles after the strobe starts
    ram_mem[32'h40] = 32'h8C22_0004;
    lat = 3;
    cyc(); iREN = 1; iaddr = 32'h40; #2;
    chk("f0_ren", ramREN, 0);
    cyc(); #2;
    chk("f1_ren", ramREN, 1);
    chk("f1_wen", ramWEN, 0);
    chk("f1_addr", ramaddr, 32'h40);
    chk("f1_iwait", iwait, 1);
    cyc(); #2;
    chk("f2_iwait", iwait, 1);
    chk("f2_iload", iload, 0);
    cyc(); #2;
    chk("f3_iwait", iwait, 0);
    chk("f3_iload", iload, 32'h8C22_0004);
    chk("f3_wen", ramWEN, 0);
    cyc(); iREN = 0; #2;
    chk("f4_iwait", iwait, 1);
    chk("f4_iload", iload, 0);
    chk("f4_ren", ramREN, 0);

    // Tie: data first, fetch on the following access
    lat = 1;
    cyc(); iREN = 1; dREN = 1; daddr = 32'h100; iaddr = 32'h44; #2;
    ip = 0; dp = 0; i_at = 0; d_at = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (dp != 0) dREN = 0;
      if (ip != 0) iREN = 0;
      #2;
      if (!dwait) begin
        dp++; d_at = k;
        chk("tie_dload", dload, dflt(32'h100));
      end
      if (!iwait) begin
        ip++; i_at = k;
        chk("tie_iload", iload, dflt(32'h44));
      end
    end
    chk("tie_dpulses", dp, 1);
    chk("tie_ipulses", ip, 1);
    chk("tie_d_cycle", d_at, 1);
    chk("tie_i_cycle", i_at, 3);

    // Store with address/data changed mid-access
    lat = 4;
    cyc(); dWEN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; #2;
    cyc(); #2;
    chk("st1_wen", ramWEN, 1);
    chk("st1_ren", ramREN, 0);
    chk("st1_addr", ramaddr, 32'h200);
    chk("st1_store", ramstore, 32'hDEAD_BEEF);
    cyc(); daddr = 32'h300; dstore = 32'h0; #2;
    chk("st2_addr", ramaddr, 32'h200);
    chk("st2_store", ramstore, 32'hDEAD_BEEF);
    chk("st2_dwait", dwait, 1);
    cyc(); #2;
    chk("st3_addr", ramaddr, 32'h200);
    cyc(); #2;
    chk("st4_dwait", dwait, 0);
    chk("st4_dload", dload, 0);
    chk("st4_store", ramstore, 32'hDEAD_BEEF);
    cyc(); dWEN = 0; #2;
    chk("st5_wen", ramWEN, 0);
    chk("st5_mem", ram_rd(32'h200), 32'hDEAD_BEEF);

    // Starvation bound: four data completions, then a fetch, repeating
    lat = 1;
    cyc(); dREN = 1; iREN = 1; daddr = 32'h104; iaddr = 32'h48; #2;
    nc = 0; seq = '0;
    for (int k = 0; k < 40 && nc < 10; k++) begin
      cyc(); #2;
      if (!iwait) begin seq[nc] = 1'b1; nc++; end
      else if (!dwait) nc++;
    end
    cyc(); dREN = 0; iREN = 0; #2;
    chk("starve_count", nc, 10);
    chk("starve_order", {22'h0, seq}, 32'h210);
    cyc(); cyc();

    // Fetch withdrawn mid-access
    lat = 3;
    cyc(); iREN = 1; iaddr = 32'h4C; #2;
    cyc(); #2;
    chk("drop1_ren", ramREN, 1);
    chk("drop1_iwait", iwait, 1);
    cyc(); iREN = 0; #2;
    chk("drop2_ren", ramREN, 1);
    chk("drop2_iwait", iwait, 1);
    cyc(); #2;
    chk("drop3_ready", ram_ready, 1);
    chk("drop3_ren", ramREN, 1);
    chk("drop3_iwait", iwait, 1);
    chk("drop3_iload", iload, 0);
    cyc(); #2;
    chk("drop4_ren", ramREN, 0);
    chk("drop4_iwait", iwait, 1);

    // Reset during a store
    lat = 10;
    cyc(); dWEN = 1; daddr = 32'h50; dstore = 32'h1234_5678; #2;
    cyc(); #2;
    chk("ra_wen", ramWEN, 1);
    #1 nRST = 1'b0;
    #1;
    chk("ra_async_wen", ramWEN, 0);
    chk("ra_async_addr", ramaddr, 0);
    chk("ra_async_store", ramstore, 0);
    dWEN = 0;
    cyc(); cyc();
    nRST = 1'b1; #2;
    chk("ra_iwait", iwait, 1);
    chk("ra_dwait", dwait, 1);
    chk("ra_iload", iload, 0);
    chk("ra_dload", dload, 0);
    chk("ra_ren", ramREN, 0);
    chk("ra_addr", ramaddr, 0);
    lat = 1;
    cyc(); iREN = 1; iaddr = 32'h40; #2;
    chk("ra_idle_ren", ramREN, 0);
    cyc(); #2;
    chk("ra_grant_ren", ramREN, 1);
    chk("ra_grant_iwait", iwait, 0);
    chk("ra_grant_iload", iload, 32'h8C22_0004);
    cyc(); iREN = 0; #2;

    // Randomized traffic against the reference memory and streak bound
    rand_lat = 1; spurious = 1;
    i_pend = 0; d_pend = 0; d_wr = 0;
    mstreak = 0; i_done_n = 0; d_done_n = 0;
    for (int c = 0; c < 3200; c++) begin
      cyc();
      if (!i_pend) begin
        iREN = 1'b0;
        if (c < 3000 && $urandom_range(0, 2) == 0) begin
          i_pend = 1; iREN = 1'b1;
          iaddr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        end
      end
      if (!d_pend) begin
        dREN = 1'b0; dWEN = 1'b0;
        if (c < 3000 && $urandom_range(0, 1) == 0) begin
          d_pend = 1;
          d_wr = ($urandom_range(0, 1) == 1);
          dWEN = d_wr;
          dREN = !d_wr || ($urandom_range(0, 3) == 0);
          daddr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
          dstore = $urandom;
        end
      end
      #2;
      chk("rnd_excl", {31'h0, ramREN & ramWEN}, 0);
      if (!iwait) begin
        chk("rnd_i_pend", {31'h0, i_pend}, 1);
        chk("rnd_iload", iload, ref_rd(iaddr));
        i_pend = 0; i_done_n++; mstreak = 0;
      end else begin
        chk("rnd_iload_idle", iload, 0);
      end
      if (!dwait) begin
        chk("rnd_d_pend", {31'h0, d_pend}, 1);
        chk("rnd_streak", {31'h0, mstreak < MAX}, 1);
        if (d_wr) begin
          ref_mem[daddr] = dstore;
          chk("rnd_dload_wr", dload, 0);
        end else begin
          chk("rnd_dload", dload, ref_rd(daddr));
        end
        mstreak = i_pend ? ((mstreak < MAX) ? mstreak + 1 : MAX) : 0;
        d_pend = 0; d_done_n++;
      end else begin
        chk("rnd_dload_idle", dload, 0);
      end
    end
    chk("rnd_i_drained", {31'h0, i_pend}, 0);
    chk("rnd_d_drained", {31'h0, d_pend}, 0);
    chk("rnd_i_served", {31'h0, i_done_n > 100}, 1);
    chk("rnd_d_served", {31'h0, d_done_n > 100}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
